uart_master: RTL and testbench
==============================

Name: uart_master

Overview:
- 16450-style UART with a byte-wide register interface and no FIFOs.
- Serialises bytes written by a host controller onto SOUT and deserialises SIN into a receive buffer.
- Provides line/modem status, interrupt and handshake pins.
- Sits between core logic (e.g. a CPU status dumper) and the board serial pins; runs entirely on the system clock.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; used only for the reset divisor.
- BAUD, 115200, reset baud rate; reset divisor = round(CLK_FREQ/(16*BAUD)), which is 27 at the defaults.

Ports:
- I_CLK  in  1  system clock; all logic on its rising edge.
- I_RESET  in  1  reset; one clock, synchronous, active-high.
- I_TX_EN  in  1  write strobe; one write per high cycle.
- I_WADDR  in  3  write register address.
- I_WDATA  in  8  write data.
- I_RX_EN  in  1  read strobe.
- I_RADDR  in  3  read register address.
- O_RDATA  out  8  read data, registered.
- SIN  in  1  serial input, asynchronous.
- SOUT  out  1  serial output.
- RxRDYn  out  1  low while receive data is ready (DR=1).
- TxRDYn  out  1  low while the holding register is empty (THRE=1).
- DDIS  out  1  high when no read is in progress (= ~I_RX_EN, registered).
- INTR  out  1  interrupt request, active-high.
- DCDn, CTSn, DSRn, RIn  in  1 each  modem status inputs, active-low.
- DTRn, RTSn  out  1 each  modem controls, = ~MCR[0] and ~MCR[1].

Behaviour:
Register map (DLAB = LCR[7]):
- 0: read RBR, write THR; DLL when DLAB=1.
- 1: IER[3:0]; DLM when DLAB=1.
- 2: read IIR; writes ignored.
- 3: LCR.
- 4: MCR[4:0].
- 5: LSR (read only).
- 6: MSR (read only).
- 7: SCR.

Reset state:
- LCR=0x03 (8N1); divisor={DLM,DLL}=reset divisor.
- IER=0, MCR=0, SCR=0, LSR=0x60, IIR=0x01.
- SOUT=1, O_RDATA=0, INTR=0, TxRDYn=0, RxRDYn=1, DTRn=RTSn=1, DDIS=1.
- Reset mid-frame aborts both TX and RX immediately.

Access timing:
- Writes take effect on the edge where I_TX_EN=1.
- Reads: O_RDATA is valid the cycle after I_RX_EN=1.
- Read side effects occur on the strobe edge:
  - RBR read clears DR.
  - LSR read clears OE, PE, FE, BI.
  - MSR read clears the delta bits [3:0].
  - IIR read clears a pending THRE interrupt when THRE is the reported source.
- Simultaneous read and write: both are performed.

Baud generation:
- A 16x tick pulses once every divisor cycles.
- Bit time = 16 ticks (432 clocks at the defaults).
- Divisor 0 stops the tick.
- Writing DLL/DLM restarts the tick counter.

LCR:
- [1:0] word length 5–8 bits.
- [2] stop bits: 2 when set (1.5 for 5-bit words is treated as 2).
- [3] parity enable; [4] even parity.
- [5] stick parity: ignored, reads back.
- [6] break: forces SOUT=0.

Transmit:
- A THR write clears THRE.
- When the shifter is idle, THR moves to the shifter on the next cycle and THRE sets again.
- The start bit begins on the next 16x tick.
- Frame order: start(0), data LSB first, optional parity, stop(1)s. TEMT (LSR[6]) =1 only when THR and shifter are both empty.
- A THR write while THRE=0 overwrites THR.

Receive:
- SIN passes through a 2-flop synchroniser.
- An idle falling edge starts a frame; the start bit is re-checked at tick 8 and the frame is discarded if SIN is high.
- Data, parity and stop are sampled at mid-bit (tick 8). Only the first stop bit is checked.
- At the stop sample the byte is loaded into RBR and DR sets.
- FE if stop=0; PE on parity mismatch; BI if all bits including stop are 0.
- If DR is already 1 when a byte completes, OE sets and RBR is overwritten.
- The receiver then waits for SIN=1 before re-arming.

Loopback (MCR[4]):
- SOUT is held at 1.
- The receiver input is the internal TX line.
- MSR inputs are taken from MCR: CTS=RTS, DSR=DTR, RI=OUT1, DCD=OUT2.

MSR:
- [7:4] = inverted DCDn, RIn, DSRn, CTSn.
- [3] DDCD, [2] TERI (RI trailing edge), [1] DDSR, [0] DCTS.
- Delta bits set on change of the synchronised inputs.

Interrupts:
- IIR priority:
  - 0x06 line status (IER[2] & any of OE/PE/FE/BI).
  - 0x04 RX data (IER[0] & DR).
  - 0x02 THRE (IER[1] & THRE pending).
  - 0x00 modem (IER[3] & any delta).
  - 0x01 none.
- THRE pending sets when THRE rises or when IER[1] is written 0→1 while THRE=1; it clears on a THR write.
- INTR = IIR[0]==0, registered.

Test Plan:
- Reset with defaults -> LSR reads 0x60, IIR 0x01, LCR 0x03, SOUT=1, TxRDYn=0, RxRDYn=1, DTRn=RTSn=1.
- Write THR=0x41 -> SOUT low for 432 clocks, then 1,0,0,0,0,0,1,0 each 432 clocks, then stop high; TxRDYn=0 again once THR moves to the shifter; TEMT=1 after the stop bit.
- Drive SIN with 8N1 0x5A at 432 clocks/bit -> DR=1, RxRDYn=0; RBR read returns 0x5A; RxRDYn returns to 1.
- Receive two bytes without reading -> LSR shows OE; RBR holds the second byte; LSR read clears OE.
- Frame with stop bit 0 -> FE=1; with IER=0x04, INTR=1 and IIR=0x06.
- Set DLAB, DLL=13, DLM=0, clear DLAB, MCR=0x10, write THR=0xC3 -> SOUT stays 1; loopback receives 0xC3 with 208-clock bit time.
- IER=0x02 with THR empty -> INTR=1, IIR=0x02; reading IIR clears INTR.

Source files
------------

// File: rtl/uart_master_if.sv
// Host register bus of the UART: one write port and one read port, both
// strobed for a single clock per access.
interface uart_master_if;
  logic       I_TX_EN;
  logic [2:0] I_WADDR;
  logic [7:0] I_WDATA;
  logic       I_RX_EN;
  logic [2:0] I_RADDR;
  logic [7:0] O_RDATA;

  modport master (output I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR, input O_RDATA);
  modport slave  (input  I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR, output O_RDATA);
endinterface

// File: rtl/uart_master.sv
// 16450-style UART without FIFOs: byte-wide register file, 16x baud tick,
// transmit shifter, oversampling receiver, modem status and interrupt logic.
module uart_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic         I_CLK,
  input  logic         I_RESET,
  uart_master_if.slave bus,
  input  logic         SIN,
  output logic         SOUT,
  output logic         RxRDYn,
  output logic         TxRDYn,
  output logic         DDIS,
  output logic         INTR,
  input  logic         DCDn,
  input  logic         CTSn,
  input  logic         DSRn,
  input  logic         RIn,
  output logic         DTRn,
  output logic         RTSn
);
  localparam int          RST_DIV_I = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam logic [15:0] RST_DIV   = 16'(RST_DIV_I);

  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_HOLD} rx_state_t;

  logic [7:0] lcr, scr, dll, dlm, thr, rbr, rdata_q, rd_mux, iir, tx_shift, rx_shift;
  logic [3:0] ier, msr_delta, msr_chg, mdm_s1, mdm_s2, mdm_cur, mdm_prev, tx_tick, rx_tick;
  logic [4:0] mcr;
  logic [2:0] tx_bitn, rx_bitn, wlen_last;
  logic [15:0] div_cnt, divisor;
  logic dr, oe, pe, fe, bi, thre, thre_pend, temt, intr_q, ddis_q, tick;
  logic wr_thr, wr_div, ier_thre_rise, rd_rbr, rd_lsr, rd_msr, rd_iir;
  logic tx_load, tx_line, tx_ser_q, tx_par, tx_stopn, tx_bit_end;
  logic rx_s1, rx_s2, rx_in, rx_mid, rx_done, rx_xor, rx_any1, rx_perr;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  wire dlab = lcr[7];
  assign divisor   = {dlm, dll};
  assign wlen_last = {1'b1, lcr[1:0]};  // index of the last data bit, 4..7

  assign wr_thr = bus.I_TX_EN && bus.I_WADDR == 3'd0 && !dlab;
  assign wr_div = bus.I_TX_EN && dlab && (bus.I_WADDR == 3'd0 || bus.I_WADDR == 3'd1);
  assign ier_thre_rise = bus.I_TX_EN && bus.I_WADDR == 3'd1 && !dlab &&
                         bus.I_WDATA[1] && !ier[1] && thre;
  assign rd_rbr = bus.I_RX_EN && bus.I_RADDR == 3'd0 && !dlab;
  assign rd_iir = bus.I_RX_EN && bus.I_RADDR == 3'd2;
  assign rd_lsr = bus.I_RX_EN && bus.I_RADDR == 3'd5;
  assign rd_msr = bus.I_RX_EN && bus.I_RADDR == 3'd6;

  // 16x baud tick; a divisor write restarts the count, divisor 0 stalls it.
  assign tick = (divisor != 16'd0) && (div_cnt == divisor - 16'd1);
  always_ff @(posedge I_CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (I_RESET || wr_div || tick) div_cnt <= 16'd0;
    else if (divisor != 16'd0)     div_cnt <= div_cnt + 16'd1;
  end

  // Transmit FSM state register.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  // Transmit next-state and serial line value.
  assign tx_bit_end = tick && tx_tick == 4'd15;
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    tx_next = tx_state;
    tx_load = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE:  if (!thre) begin tx_load = 1'b1; tx_next = TX_WAIT; end
      TX_WAIT:  if (tick) tx_next = TX_START;
      TX_START: begin tx_line = 1'b0; if (tx_bit_end) tx_next = TX_DATA; end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end && tx_bitn == wlen_last) tx_next = lcr[3] ? TX_PAR : TX_STOP;
      end
      TX_PAR:  begin tx_line = tx_par; if (tx_bit_end) tx_next = TX_STOP; end
      TX_STOP: if (tx_bit_end && (tx_stopn || !lcr[2])) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // Transmit shifter, bit counters and the registered line (break applied).
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      tx_shift <= 8'h00; tx_par <= 1'b0; tx_bitn <= 3'd0; tx_stopn <= 1'b0;
      tx_tick  <= 4'd0;  tx_ser_q <= 1'b1;
    end else begin
      tx_ser_q <= lcr[6] ? 1'b0 : tx_line;
      if (tx_load) begin
        tx_shift <= thr;
        tx_par   <= ^(thr & (8'hFF >> (~lcr[1:0]))) ^ ~lcr[4];
        tx_bitn  <= 3'd0;
        tx_stopn <= 1'b0;
      end else if (tx_bit_end) begin
        if (tx_state == TX_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bitn  <= tx_bitn + 3'd1;
        end
        if (tx_state == TX_STOP) tx_stopn <= 1'b1;
      end
      if (tick) tx_tick <= (tx_state == TX_WAIT) ? 4'd0 : tx_tick + 4'd1;
    end
  end
  assign temt = thre && tx_state == TX_IDLE;

  // SIN synchroniser; loopback feeds the receiver from the transmit line.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin rx_s1 <= 1'b1; rx_s2 <= 1'b1; end
    else         begin rx_s1 <= SIN;  rx_s2 <= rx_s1; end
  end
  assign rx_in = mcr[4] ? tx_ser_q : rx_s2;

  // Receive FSM state register; reset waits for an idle-high line.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) rx_state <= RX_HOLD;
    else         rx_state <= rx_next;
  end

  // Receive next-state: mid-bit is tick 8 of the start bit, then every 16.
  assign rx_mid = tick && (rx_state == RX_START ? rx_tick == 4'd7 : rx_tick == 4'd15);
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_in) rx_next = RX_START;
      RX_START: if (rx_mid) rx_next = rx_in ? RX_HOLD : RX_DATA;
      RX_DATA:  if (rx_mid && rx_bitn == wlen_last) rx_next = lcr[3] ? RX_PAR : RX_STOP;
      RX_PAR:   if (rx_mid) rx_next = RX_STOP;
      RX_STOP:  if (rx_mid) begin rx_done = 1'b1; rx_next = RX_HOLD; end
      RX_HOLD:  if (rx_in) rx_next = RX_IDLE;
      default:  rx_next = RX_HOLD;
    endcase
  end

  // Receive sampling: assemble data, track parity and all-zero frames.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      rx_tick <= 4'd0; rx_bitn <= 3'd0; rx_shift <= 8'h00; rx_xor <= 1'b0;
      rx_any1 <= 1'b0; rx_perr <= 1'b0; rbr <= 8'h00;
    end else if (rx_state == RX_IDLE) begin
      rx_tick <= 4'd0; rx_bitn <= 3'd0; rx_shift <= 8'h00; rx_xor <= 1'b0;
      rx_any1 <= 1'b0; rx_perr <= 1'b0;
    end else begin
      if (tick) rx_tick <= (rx_state == RX_START && rx_tick == 4'd7) ? 4'd0 : rx_tick + 4'd1;
      if (rx_mid) begin
        case (rx_state)
          RX_DATA: begin
            rx_shift[rx_bitn] <= rx_in;
            rx_xor  <= rx_xor ^ rx_in;
            rx_any1 <= rx_any1 | rx_in;
            rx_bitn <= rx_bitn + 3'd1;
          end
          RX_PAR: begin
            rx_perr <= rx_xor ^ rx_in ^ ~lcr[4];
            rx_any1 <= rx_any1 | rx_in;
          end
          RX_STOP: rbr <= rx_shift;
          default: ;
        endcase
      end
    end
  end

  // Modem inputs, active-high after inversion: {DCD, RI, DSR, CTS}.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin mdm_s1 <= 4'd0; mdm_s2 <= 4'd0; mdm_prev <= 4'd0; end
    else begin
      mdm_s1   <= {~DCDn, ~RIn, ~DSRn, ~CTSn};
      mdm_s2   <= mdm_s1;
      mdm_prev <= mdm_cur;
    end
  end
  assign mdm_cur = mcr[4] ? {mcr[3], mcr[2], mcr[0], mcr[1]} : mdm_s2;
  assign msr_chg = {mdm_prev[3] ^ mdm_cur[3], mdm_prev[2] & ~mdm_cur[2],
                    mdm_prev[1] ^ mdm_cur[1], mdm_prev[0] ^ mdm_cur[0]};

  // Interrupt identification in priority order.
  always_comb begin
    iir = 8'h01;
    if (ier[2] && (oe || pe || fe || bi)) iir = 8'h06;
    else if (ier[0] && dr)                iir = 8'h04;
    else if (ier[1] && thre_pend)         iir = 8'h02;
    else if (ier[3] && msr_delta != 4'd0) iir = 8'h00;
  end

  // Read data multiplexer.
  always_comb begin
    rd_mux = 8'h00;
    case (bus.I_RADDR)
      3'd0: rd_mux = dlab ? dll : rbr;
      3'd1: rd_mux = dlab ? dlm : {4'h0, ier};
      3'd2: rd_mux = iir;
      3'd3: rd_mux = lcr;
      3'd4: rd_mux = {3'b000, mcr};
      3'd5: rd_mux = {1'b0, temt, thre, bi, fe, pe, oe, dr};
      3'd6: rd_mux = {mdm_cur, msr_delta};
      default: rd_mux = scr;
    endcase
  end

  // Register file, status flags and read side effects; new events win over clears.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      lcr <= 8'h03; dll <= RST_DIV[7:0]; dlm <= RST_DIV[15:8];
      ier <= 4'h0; mcr <= 5'h00; scr <= 8'h00; thr <= 8'h00;
      dr <= 1'b0; oe <= 1'b0; pe <= 1'b0; fe <= 1'b0; bi <= 1'b0;
      thre <= 1'b1; thre_pend <= 1'b0; msr_delta <= 4'h0;
      rdata_q <= 8'h00; intr_q <= 1'b0; ddis_q <= 1'b1;
    end else begin
      if (bus.I_TX_EN) begin
        case (bus.I_WADDR)
          3'd0: if (dlab) dll <= bus.I_WDATA; else thr <= bus.I_WDATA;
          3'd1: if (dlab) dlm <= bus.I_WDATA; else ier <= bus.I_WDATA[3:0];
          3'd3: lcr <= bus.I_WDATA;
          3'd4: mcr <= bus.I_WDATA[4:0];
          3'd7: scr <= bus.I_WDATA;
          default: ;
        endcase
      end
      if (wr_thr)       thre <= 1'b0;
      else if (tx_load) thre <= 1'b1;
      if (wr_thr)                          thre_pend <= 1'b0;
      else if (tx_load || ier_thre_rise)   thre_pend <= 1'b1;
      else if (rd_iir && iir == 8'h02)     thre_pend <= 1'b0;
      if (rx_done)     dr <= 1'b1;
      else if (rd_rbr) dr <= 1'b0;
      if (rx_done && dr)                    oe <= 1'b1; else if (rd_lsr) oe <= 1'b0;
      if (rx_done && lcr[3] && rx_perr)     pe <= 1'b1; else if (rd_lsr) pe <= 1'b0;
      if (rx_done && !rx_in)                fe <= 1'b1; else if (rd_lsr) fe <= 1'b0;
      if (rx_done && !(rx_any1 || rx_in))   bi <= 1'b1; else if (rd_lsr) bi <= 1'b0;
      msr_delta <= (rd_msr ? 4'h0 : msr_delta) | msr_chg;
      if (bus.I_RX_EN) rdata_q <= rd_mux;
      ddis_q <= ~bus.I_RX_EN;
      intr_q <= ~iir[0];
    end
  end

  assign bus.O_RDATA = rdata_q;
  assign SOUT   = mcr[4] ? 1'b1 : tx_ser_q;
  assign RxRDYn = ~dr;
  assign TxRDYn = ~thre;
  assign DDIS   = ddis_q;
  assign INTR   = intr_q;
  assign DTRn   = ~mcr[0];
  assign RTSn   = ~mcr[1];
endmodule

// File: tb/tb_uart_master.sv
// Directed bench for uart_master at the default 50 MHz / 115200 baud
// (divisor 27, 432 clocks per bit).
module tb_uart_master;
  logic I_CLK = 1'b0;
  logic I_RESET = 1'b1;
  logic SIN = 1'b1;
  logic DCDn = 1'b1, CTSn = 1'b1, DSRn = 1'b1, RIn = 1'b1;
  logic SOUT, RxRDYn, TxRDYn, DDIS, INTR, DTRn, RTSn;
  int checks = 0;
  int errors = 0;

  uart_master_if bus ();

  uart_master #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
    .I_CLK (I_CLK), .I_RESET(I_RESET), .bus(bus.slave),
    .SIN   (SIN),   .SOUT  (SOUT),   .RxRDYn(RxRDYn), .TxRDYn(TxRDYn),
    .DDIS  (DDIS),  .INTR  (INTR),
    .DCDn  (DCDn),  .CTSn  (CTSn),   .DSRn  (DSRn),   .RIn   (RIn),
    .DTRn  (DTRn),  .RTSn  (RTSn)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge I_CLK);
    bus.I_TX_EN = 1'b1; bus.I_WADDR = a; bus.I_WDATA = d;
    @(negedge I_CLK);
    bus.I_TX_EN = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge I_CLK);
    bus.I_RX_EN = 1'b1; bus.I_RADDR = a;
    @(negedge I_CLK);
    bus.I_RX_EN = 1'b0;
    d = bus.O_RDATA;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    rd(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  // Drives bits[0..n-1] onto SIN, each held for bt clocks.
  task automatic drive_frame(input logic [9:0] bits, input int n, input int bt);
    for (int i = 0; i < n; i++) begin
      SIN = bits[i];
      repeat (bt) @(negedge I_CLK);
    end
  endtask

  // Waits (bounded) for SOUT to go low.
  task automatic wait_sout_low(input string tag);
    int n = 0;
    while (SOUT !== 1'b0 && n < 2000) begin
      @(negedge I_CLK);
      n++;
    end
    chk1(tag, SOUT, 1'b0);
  endtask

  initial begin
    logic [8:0] fr;
    logic       seen_low;
    int         n;

    bus.I_TX_EN = 1'b0; bus.I_WADDR = 3'd0; bus.I_WDATA = 8'h00;
    bus.I_RX_EN = 1'b0; bus.I_RADDR = 3'd0;
    repeat (3) @(negedge I_CLK);
    I_RESET = 1'b0;
    @(negedge I_CLK);

    // Reset state
    chk1("rst_sout", SOUT, 1'b1);
    chk1("rst_txrdyn", TxRDYn, 1'b0);
    chk1("rst_rxrdyn", RxRDYn, 1'b1);
    chk1("rst_dtrn", DTRn, 1'b1);
    chk1("rst_rtsn", RTSn, 1'b1);
    chk1("rst_ddis", DDIS, 1'b1);
    chk1("rst_intr", INTR, 1'b0);
    check("rst_rdata", {8'h00, bus.O_RDATA}, 16'h0000);
    rd_check(3'd5, 8'h60, "rst_lsr");
    chk1("ddis_during_read", DDIS, 1'b0);
    rd_check(3'd2, 8'h01, "rst_iir");
    rd_check(3'd3, 8'h03, "rst_lcr");
    wr(3'd3, 8'h83);
    rd_check(3'd0, 8'd27, "rst_dll");
    rd_check(3'd1, 8'h00, "rst_dlm");
    wr(3'd3, 8'h03);
    wr(3'd7, 8'hA5);
    rd_check(3'd7, 8'hA5, "scr_rw");

    // Break forces SOUT low
    wr(3'd3, 8'h43);
    @(negedge I_CLK);
    chk1("break_sout", SOUT, 1'b0);
    wr(3'd3, 8'h03);
    @(negedge I_CLK);
    chk1("break_release", SOUT, 1'b1);

    // Transmit 0x41 in 8N1
    wr(3'd0, 8'h41);
    chk1("thr_full_txrdyn", TxRDYn, 1'b1);
    @(negedge I_CLK);
    chk1("thr_moved_txrdyn", TxRDYn, 1'b0);
    wait_sout_low("tx_start_seen");
    n = 0;
    while (SOUT === 1'b0 && n < 1000) begin
      n++;
      @(negedge I_CLK);
    end
    check("tx_start_len", 16'(n), 16'd432);
    for (int i = 0; i < 9; i++) begin
      repeat ((i == 0) ? 216 : 432) @(negedge I_CLK);
      fr[i] = SOUT;
    end
    check("tx_frame", {7'd0, fr}, {7'd0, 9'h141});
    rd_check(3'd5, 8'h20, "lsr_during_stop");
    repeat (400) @(negedge I_CLK);
    rd_check(3'd5, 8'h60, "lsr_temt_after");

    // Receive 0x5A
    drive_frame({1'b1, 8'h5A, 1'b0}, 10, 432);
    chk1("rx_rxrdyn_low", RxRDYn, 1'b0);
    rd_check(3'd5, 8'h61, "rx_lsr_dr");
    rd_check(3'd0, 8'h5A, "rx_rbr");
    chk1("rx_rxrdyn_high", RxRDYn, 1'b1);

    // Overrun: two bytes without reading
    drive_frame({1'b1, 8'h11, 1'b0}, 10, 432);
    drive_frame({1'b1, 8'h22, 1'b0}, 10, 432);
    rd_check(3'd5, 8'h63, "ovr_lsr");
    rd_check(3'd0, 8'h22, "ovr_rbr");
    rd_check(3'd5, 8'h60, "ovr_cleared");

    // Framing error with line-status interrupt enabled
    wr(3'd1, 8'h04);
    drive_frame({1'b0, 8'h33, 1'b0}, 10, 432);
    SIN = 1'b1;
    repeat (20) @(negedge I_CLK);
    chk1("fe_intr", INTR, 1'b1);
    rd_check(3'd2, 8'h06, "fe_iir");
    rd_check(3'd5, 8'h69, "fe_lsr");
    rd_check(3'd0, 8'h33, "fe_rbr");
    rd_check(3'd2, 8'h01, "fe_iir_clear");

    // Break condition: all-zero frame including stop
    drive_frame(10'd0, 10, 432);
    SIN = 1'b1;
    repeat (20) @(negedge I_CLK);
    rd_check(3'd5, 8'h79, "bi_lsr");
    rd_check(3'd0, 8'h00, "bi_rbr");
    wr(3'd1, 8'h00);

    // Loopback at divisor 13
    wr(3'd3, 8'h83);
    wr(3'd0, 8'd13);
    wr(3'd1, 8'd0);
    wr(3'd3, 8'h03);
    wr(3'd4, 8'h10);
    wr(3'd0, 8'hC3);
    seen_low = 1'b0;
    n = 0;
    while (RxRDYn !== 1'b0 && n < 5000) begin
      @(negedge I_CLK);
      n++;
      if (SOUT !== 1'b1) seen_low = 1'b1;
    end
    chk1("lb_sout_idle", seen_low, 1'b0);
    chk1("lb_bit_time", (n >= 1970 && n <= 2000), 1'b1);
    rd_check(3'd0, 8'hC3, "lb_rbr");
    wr(3'd4, 8'h13);
    chk1("lb_dtrn", DTRn, 1'b0);
    chk1("lb_rtsn", RTSn, 1'b0);
    rd_check(3'd6, 8'h33, "lb_msr");
    rd_check(3'd6, 8'h30, "lb_msr_clear");
    wr(3'd4, 8'h00);
    repeat (4) @(negedge I_CLK);
    rd_check(3'd6, 8'h03, "msr_after_loop");

    // THRE interrupt and its clear by IIR read
    wr(3'd1, 8'h02);
    repeat (2) @(negedge I_CLK);
    chk1("thre_intr", INTR, 1'b1);
    rd_check(3'd2, 8'h02, "thre_iir");
    repeat (2) @(negedge I_CLK);
    chk1("thre_intr_clear", INTR, 1'b0);
    rd_check(3'd2, 8'h01, "thre_iir_clear");
    wr(3'd1, 8'h00);

    // Reset in the middle of a frame
    wr(3'd0, 8'h55);
    wait_sout_low("rst_mid_start");
    @(negedge I_CLK);
    I_RESET = 1'b1;
    @(negedge I_CLK);
    I_RESET = 1'b0;
    chk1("rst_mid_sout", SOUT, 1'b1);
    chk1("rst_mid_txrdyn", TxRDYn, 1'b0);
    rd_check(3'd5, 8'h60, "rst_mid_lsr");
    repeat (500) @(negedge I_CLK);
    chk1("rst_mid_idle", SOUT, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
